// File: rtl/xadc_drp_arbiter.sv
// Arbitrates the single XADC DRP port between end-of-conversion auto-reads and host register access.
// Optional build macro XADC_ARB_TIMEOUT_EN adds a drdy watchdog that aborts a stuck transaction.
module xadc_drp_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  output logic        den_out,
  output logic        dwe_out,
  output logic [6:0]  daddr_out,
  output logic [15:0] di_out,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        sample_valid,
  output logic [4:0]  sample_chan,
  output logic [11:0] sample_data,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t     state, state_nxt;
  logic       pending;
  logic [4:0] pend_chan;
  logic       txn_host;
  logic       grant_auto, grant_host, drdy_done, timeout_hit, eoc_overrun;

  // Host handshake: host_req is the valid and stays high with stable fields until
  // host_ack (a one-cycle done pulse); the host is never regranted while host_ack is high.
  // An eoc_in seen in IDLE defers the host one cycle so the auto-read always wins a tie.
  assign grant_auto  = (state == IDLE) && pending;
  assign grant_host  = (state == IDLE) && !pending && !eoc_in && host_req && !host_ack;
  assign drdy_done   = (state == WAIT) && drdy_in;
  assign eoc_overrun = eoc_in && pending && !grant_auto;

`ifdef XADC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               wait_cnt <= '0;
    else if (state != WAIT)  wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == WAIT) && !drdy_in && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_auto || grant_host) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (drdy_done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    den_out = (state == ISSUE);
    busy    = (state != IDLE);
  end

  // A new eoc always re-arms the pending flag, even in the cycle it is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= 1'b0;
      pend_chan <= '0;
      overrun   <= 1'b0;
    end else begin
      if (eoc_in) begin
        pending   <= 1'b1;
        pend_chan <= channel_in;
      end else if (grant_auto) begin
        pending <= 1'b0;
      end
      if (eoc_overrun)      overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txn_host     <= 1'b0;
      dwe_out      <= 1'b0;
      daddr_out    <= '0;
      di_out       <= '0;
      sample_valid <= 1'b0;
      sample_chan  <= '0;
      sample_data  <= '0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
    end else begin
      if (grant_auto) begin
        txn_host  <= 1'b0;
        dwe_out   <= 1'b0;
        daddr_out <= {2'b00, pend_chan};
        di_out    <= '0;
      end else if (grant_host) begin
        txn_host  <= 1'b1;
        dwe_out   <= host_we;
        daddr_out <= host_addr;
        di_out    <= host_wdata;
      end
      sample_valid <= drdy_done && !txn_host;
      host_ack     <= (drdy_done || timeout_hit) && txn_host;
      if (drdy_done && !txn_host) begin
        sample_chan <= daddr_out[4:0];
        sample_data <= do_in[15:4];
      end
      if (timeout_hit && txn_host)
        host_rdata <= 16'hDEAD;
      else if (drdy_done && txn_host)
        host_rdata <= dwe_out ? 16'h0000 : do_in;
    end
  end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Self-checking bench for xadc_drp_arbiter: directed scenarios followed by randomized
// auto-read / host traffic checked against a request-level reference model.
module tb_xadc_drp_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        eoc_in;
  logic [4:0]  channel_in;
  logic        den_out, dwe_out;
  logic [6:0]  daddr_out;
  logic [15:0] di_out;
  logic        drdy_in;
  logic [15:0] do_in;
  logic        host_req, host_we;
  logic [6:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        sample_valid;
  logic [4:0]  sample_chan;
  logic [11:0] sample_data;
  logic        overrun, overrun_clr, timeout_err, busy;

  int n_assert = 0;
  int n_fail   = 0;
  // Expected DRP requests: {is_host, we, addr[6:0], wdata[15:0]}
  logic [31:0] exp_q[$];

  xadc_drp_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .eoc_in(eoc_in), .channel_in(channel_in),
    .den_out(den_out), .dwe_out(dwe_out), .daddr_out(daddr_out), .di_out(di_out),
    .drdy_in(drdy_in), .do_in(do_in),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .sample_valid(sample_valid), .sample_chan(sample_chan), .sample_data(sample_data),
    .overrun(overrun), .overrun_clr(overrun_clr), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_den(output int n);
    n = 0;
    while (den_out !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("den_wait_bound", {31'b0, den_out}, 32'd1);
  endtask

  // Serve one DRP transaction: capture the request, answer after `delay` cycles,
  // capture the completion outputs, then look one cycle further.
  task automatic serve(input int delay, input logic [15:0] data, input logic is_host,
                       output int n, output logic [6:0] addr, output logic we,
                       output logic [15:0] di, output logic sv, output logic ha,
                       output logic [4:0] sc, output logic [11:0] sd,
                       output logic [15:0] hr, output logic den_after);
    wait_den(n);
    addr = daddr_out;
    we   = dwe_out;
    di   = di_out;
    if (is_host) begin
      host_addr  = 7'($urandom);
      host_wdata = 16'($urandom);
      host_we    = 1'($urandom);
    end
    tick();
    chk("den_one_cycle", {31'b0, den_out}, 32'd0);
    chk("busy_in_wait", {31'b0, busy}, 32'd1);
    chk("addr_latched", {25'b0, daddr_out}, {25'b0, addr});
    chk("wdata_latched", {16'b0, di_out}, {16'b0, di});
    repeat (delay - 1) tick();
    drdy_in = 1'b1;
    do_in   = data;
    tick();
    drdy_in = 1'b0;
    do_in   = 16'($urandom);
    sv = sample_valid;
    ha = host_ack;
    sc = sample_chan;
    sd = sample_data;
    hr = host_rdata;
    tick();
    den_after = den_out;
    chk("pulse_one_cycle", {30'b0, sample_valid, host_ack}, 32'd0);
    if (is_host) host_req = 1'b0;
  endtask

  initial begin
    int          n, mode, first, cnt, dly;
    logic [31:0] e;
    logic [4:0]  ch;
    logic [6:0]  ha_r, addr;
    logic        hw, we, sv, ha, den_after;
    logic [15:0] hd, di, hr, data;
    logic [4:0]  sc;
    logic [11:0] sd;

    reset = 1'b1; eoc_in = 1'b0; channel_in = '0; drdy_in = 1'b0; do_in = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; overrun_clr = 1'b0;
    tick(); tick();
    chk("rst_den", {31'b0, den_out}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ack", {31'b0, host_ack}, 0);
    chk("rst_sv", {31'b0, sample_valid}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    chk("rst_timeout", {31'b0, timeout_err}, 0);
    chk("rst_daddr", {25'b0, daddr_out}, 0);
    reset = 1'b0;
    tick();

    // Auto-read of channel 0x13, drdy three cycles after den
    eoc_in = 1'b1; channel_in = 5'h13;
    tick();
    eoc_in = 1'b0;
    chk("eoc_lat_1", {31'b0, den_out}, 0);
    tick();
    chk("eoc_lat_2", {31'b0, den_out}, 1);
    chk("auto_daddr", {25'b0, daddr_out}, 32'h13);
    chk("auto_dwe", {31'b0, dwe_out}, 0);
    tick();
    chk("auto_den_drop", {31'b0, den_out}, 0);
    tick(); tick();
    drdy_in = 1'b1; do_in = 16'hABC0;
    tick();
    drdy_in = 1'b0;
    chk("auto_sv", {31'b0, sample_valid}, 1);
    chk("auto_sdata", {20'b0, sample_data}, 32'hABC);
    chk("auto_schan", {27'b0, sample_chan}, 32'h13);
    tick();
    chk("auto_sv_end", {31'b0, sample_valid}, 0);
    chk("auto_idle", {31'b0, busy}, 0);

    // Host write
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'h41; host_wdata = 16'h2000;
    tick();
    chk("hw_den", {31'b0, den_out}, 1);
    chk("hw_dwe", {31'b0, dwe_out}, 1);
    chk("hw_di", {16'b0, di_out}, 32'h2000);
    chk("hw_daddr", {25'b0, daddr_out}, 32'h41);
    tick();
    drdy_in = 1'b1; do_in = 16'h5555;
    tick();
    drdy_in = 1'b0;
    chk("hw_ack", {31'b0, host_ack}, 1);
    chk("hw_rdata", {16'b0, host_rdata}, 0);
    tick();
    chk("hw_no_regrant", {31'b0, den_out}, 0);
    chk("hw_ack_end", {31'b0, host_ack}, 0);
    host_req = 1'b0;

    // Simultaneous eoc and host read: auto-read first
    eoc_in = 1'b1; channel_in = 5'h05;
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h22; host_wdata = 16'h0;
    tick();
    eoc_in = 1'b0;
    chk("tie_no_host", {31'b0, den_out}, 0);
    tick();
    chk("tie_auto_den", {31'b0, den_out}, 1);
    chk("tie_auto_addr", {25'b0, daddr_out}, 32'h05);
    tick();
    drdy_in = 1'b1; do_in = 16'h1230;
    tick();
    drdy_in = 1'b0;
    chk("tie_sv", {31'b0, sample_valid}, 1);
    chk("tie_sdata", {20'b0, sample_data}, 32'h123);
    tick();
    chk("tie_host_den", {31'b0, den_out}, 1);
    chk("tie_host_addr", {25'b0, daddr_out}, 32'h22);
    tick();
    drdy_in = 1'b1; do_in = 16'hBEEF;
    tick();
    drdy_in = 1'b0;
    chk("tie_ack", {31'b0, host_ack}, 1);
    chk("tie_rdata", {16'b0, host_rdata}, 32'hBEEF);
    tick();
    host_req = 1'b0;

    // Host read with no drdy
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h10;
    tick();
    chk("stall_den", {31'b0, den_out}, 1);
`ifdef XADC_ARB_TIMEOUT_EN
    repeat (8) tick();
    chk("to_not_yet", {31'b0, host_ack}, 0);
    chk("to_busy_before", {31'b0, busy}, 1);
    tick();
    chk("to_ack", {31'b0, host_ack}, 1);
    chk("to_rdata", {16'b0, host_rdata}, 32'hDEAD);
    chk("to_err", {31'b0, timeout_err}, 1);
    chk("to_busy", {31'b0, busy}, 0);
    tick();
    host_req = 1'b0;
    chk("to_err_sticky", {31'b0, timeout_err}, 1);
    chk("to_no_regrant", {31'b0, den_out}, 0);
`else
    repeat (20) tick();
    chk("stall_busy", {31'b0, busy}, 1);
    chk("stall_no_ack", {31'b0, host_ack}, 0);
    chk("stall_no_timeout", {31'b0, timeout_err}, 0);
    drdy_in = 1'b1; do_in = 16'h0042;
    tick();
    drdy_in = 1'b0;
    chk("stall_ack", {31'b0, host_ack}, 1);
    chk("stall_rdata", {16'b0, host_rdata}, 32'h0042);
    tick();
    host_req = 1'b0;
`endif

    // Overrun while a host read waits
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h05;
    tick();
    chk("ovr_host_den", {31'b0, den_out}, 1);
    tick();
    eoc_in = 1'b1; channel_in = 5'h12;
    tick();
    eoc_in = 1'b0;
    chk("ovr_first_eoc", {31'b0, overrun}, 0);
    eoc_in = 1'b1; channel_in = 5'h19;
    tick();
    eoc_in = 1'b0;
    chk("ovr_set", {31'b0, overrun}, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", {31'b0, overrun}, 0);
    eoc_in = 1'b1; channel_in = 5'h1A; overrun_clr = 1'b1;
    tick();
    eoc_in = 1'b0; overrun_clr = 1'b0;
    chk("ovr_beats_clr", {31'b0, overrun}, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr2", {31'b0, overrun}, 0);
    drdy_in = 1'b1; do_in = 16'h1234;
    tick();
    drdy_in = 1'b0;
    chk("ovr_host_ack", {31'b0, host_ack}, 1);
    chk("ovr_host_rdata", {16'b0, host_rdata}, 32'h1234);
    eoc_in = 1'b1; channel_in = 5'h07;
    tick();
    eoc_in = 1'b0; host_req = 1'b0;
    chk("ovr_auto_den", {31'b0, den_out}, 1);
    chk("ovr_newest_chan", {25'b0, daddr_out}, 32'h1A);
    chk("consume_no_ovr", {31'b0, overrun}, 0);
    tick();
    drdy_in = 1'b1; do_in = 16'h5670;
    tick();
    drdy_in = 1'b0;
    chk("ovr_sv", {31'b0, sample_valid}, 1);
    chk("ovr_schan", {27'b0, sample_chan}, 32'h1A);
    chk("ovr_sdata", {20'b0, sample_data}, 32'h567);
    tick();
    chk("rearm_den", {31'b0, den_out}, 1);
    chk("rearm_chan", {25'b0, daddr_out}, 32'h07);
    tick();
    drdy_in = 1'b1; do_in = 16'h7770;
    tick();
    drdy_in = 1'b0;
    chk("rearm_sv", {31'b0, sample_valid}, 1);
    chk("rearm_schan", {27'b0, sample_chan}, 32'h07);
    cnt = 0;
    repeat (6) begin
      tick();
      cnt += int'(den_out);
    end
    chk("no_extra_read", cnt, 0);

    // Reset during WAIT abandons the read; stray drdy in IDLE is ignored
    eoc_in = 1'b1; channel_in = 5'h03;
    tick();
    eoc_in = 1'b0;
    tick();
    chk("rw_den", {31'b0, den_out}, 1);
    tick();
    chk("rw_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    #1;
    chk("rw_async_den", {31'b0, den_out}, 0);
    chk("rw_async_busy", {31'b0, busy}, 0);
    drdy_in = 1'b1; do_in = 16'hFFF0;
    tick();
    reset = 1'b0;
    tick();
    drdy_in = 1'b0;
    cnt = 0;
    repeat (4) begin
      tick();
      cnt += int'(sample_valid) + int'(host_ack) + int'(busy);
    end
    chk("rw_no_pulse", cnt, 0);
    eoc_in = 1'b1; channel_in = 5'h0F;
    tick();
    eoc_in = 1'b0;
    tick();
    chk("rw_fresh_den", {31'b0, den_out}, 1);
    chk("rw_fresh_addr", {25'b0, daddr_out}, 32'h0F);
    tick();
    drdy_in = 1'b1; do_in = 16'h0F00;
    tick();
    drdy_in = 1'b0;
    chk("rw_fresh_sv", {31'b0, sample_valid}, 1);
    chk("rw_fresh_schan", {27'b0, sample_chan}, 32'h0F);
    chk("rw_fresh_sdata", {20'b0, sample_data}, 32'h0F0);

    // Randomized traffic: 0 = eoc only, 1 = host only, 2 = both in the same cycle
    for (int it = 0; it < 30; it++) begin
      mode = int'($urandom_range(0, 2));
      ch   = 5'($urandom);
      ha_r = 7'($urandom);
      hw   = 1'($urandom);
      hd   = 16'($urandom);
      if (mode != 1) begin
        eoc_in = 1'b1; channel_in = ch;
        exp_q.push_back({7'b0, 1'b0, 1'b0, 2'b00, ch, 16'h0000});
      end
      if (mode != 0) begin
        host_req = 1'b1; host_we = hw; host_addr = ha_r; host_wdata = hd;
        exp_q.push_back({7'b0, 1'b1, hw, ha_r, hd});
      end
      tick();
      eoc_in = 1'b0;
      channel_in = 5'($urandom);
      first = 1;
      while (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        dly  = int'($urandom_range(1, 4));
        data = 16'($urandom);
        serve(dly, data, e[24], n, addr, we, di, sv, ha, sc, sd, hr, den_after);
        chk("rnd_latency", n, (first == 1) ? ((mode == 1) ? 0 : 1) : 0);
        chk("rnd_addr", {25'b0, addr}, {25'b0, e[22:16]});
        chk("rnd_we", {31'b0, we}, {31'b0, e[23]});
        if (e[24]) begin
          chk("rnd_wdata", {16'b0, di}, {16'b0, e[15:0]});
          chk("rnd_ack", {30'b0, sv, ha}, 32'd1);
          chk("rnd_rdata", {16'b0, hr}, e[23] ? 32'h0 : {16'b0, data});
        end else begin
          chk("rnd_sv", {30'b0, sv, ha}, 32'd2);
          chk("rnd_schan", {27'b0, sc}, {27'b0, e[20:16]});
          chk("rnd_sdata", {20'b0, sd}, {20'b0, data[15:4]});
        end
        chk("rnd_next_grant", {31'b0, den_after}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
        first = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
